ball_motion: RTL and testbench
==============================

// Module: ball_motion
// PURPOSE
//  Generates the ball position that the candidate/plate finder consumes.
//  Steps the ball one cell diagonally every STEP_DIV clocks.
//  Reflects the ball off the top/bottom walls and off the paddles.
//  Reports a miss when the ball reaches an edge column with no paddle behind it.
//  Sits between the paddle controllers and the plate finder/renderer in the pong datapath.
// PARAMETERS
//  WIDTH         16  field size in cells, square; rows/cols 0 and WIDTH-1 are walls/paddle columns
//  BIT_OF_WIDTH  4   coordinate width, log2(WIDTH)
//  STEP_DIV      4   clocks per ball step, >=2
//  PADDLE_LEN    4   paddle length in cells
// PORTS
//  clk        in   1    system clock, rising edge
//  rst        in   1    asynchronous reset, active-high
//  start      in   1    serve request; honoured only in IDLE
//  lpad_y     in   BW   left paddle top row; covers lpad_y..lpad_y+PADDLE_LEN-1
//  rpad_y     in   BW   right paddle top row; same rule
//  pos        out  2BW  ball position {x,y}; x = column, y = row
//  pos_valid  out  1    one-cycle pulse in the cycle pos changes
//  miss_left  out  1    one-cycle pulse; ball passed the left paddle
//  miss_right out  1    one-cycle pulse; ball passed the right paddle
//  running    out  1    1 while in RUN
// BEHAVIOUR
//  Reset values:
//   - pos={7,7} (centre, WIDTH/2-1); dx=1 (+x); dy=1 (+y)
//   - state=IDLE; tick counter=0; all pulse outputs=0; running=0
//   - rst acts immediately, mid-step included.
//  FSM (IDLE, RUN, MISS):
//   - IDLE: start=1 -> RUN, counter cleared.
//   - RUN: counter counts 0..STEP_DIV-1; at STEP_DIV-1 one step executes and the counter wraps to 0.
//   - So the first step lands STEP_DIV clocks after the start cycle.
//   - MISS: lasts exactly one cycle, miss_* high; pos reloads to centre; -> IDLE.
//   - start is ignored in RUN and MISS.
//  Step rules: all from current registered values, computed in one cycle.
//   - Y axis (ball rows 1..WIDTH-2):
//     - dy=0 & y=1 -> dy<=1, y<=2
//     - dy=1 & y=WIDTH-2 -> dy<=0, y<=WIDTH-3
//     - otherwise y<=y+/-1
//   - X axis (ball cols 1..WIDTH-2):
//     - dx=0 & x=1 & left hit -> dx<=1, x<=2
//     - dx=0 & x=1 & no hit -> MISS, miss_left
//     - dx=1 & x=WIDTH-2 mirrors this with rpad_y and miss_right
//     - otherwise x<=x+/-1
//   - Hit test uses the CURRENT y: pad_y <= y <= pad_y+PADDLE_LEN-1.
//     - Evaluated in BW+1 bits so there is no wrap.
//     - pad_y = 14 covers rows 14..17 only.
//   - Corner cell (x and y both at limits): both axes reflect in the same step, e.g. (14,14) -> (13,13).
//  Miss handling:
//   - pos_valid pulses on every normal step; no pos_valid on a miss step.
//   - On a miss, pos goes to centre. The serve direction points at the side that missed: miss_left -> dx=0, miss_right -> dx=1.
//   - dy is kept.
//  Paddle inputs: sampled only at step cycles; changes between steps have no effect.
// STRUCTURE
//  Shared package pong_pkg holds:
//   - WIDTH, BIT_OF_WIDTH
//   - wall/limit constants: MIN_POS=1, MAX_POS=WIDTH-2, CENTRE
//   - the state encoding (IDLE, RUN, MISS)
//  The plate finder uses the same constants.
//  One sub-module: step_timer.
//   - STEP_DIV counter with clear input; emits a step strobe.
//  The FSM and position/direction registers live in ball_motion.
// TESTING
//  Defaults apply: STEP_DIV=4, WIDTH=16, PADDLE_LEN=4.
//  1. Reset released, start pulsed at cycle 0.
//     -> pos=0x77 until cycle 4.
//     -> pos=0x88 with pos_valid at cycle 4; 0x99 at cycle 8.
//  2. Corner, rpad_y=12, serve from centre.
//     -> 7th step reaches 0xEE; 8th step gives 0xDD.
//     -> dx=0, dy=0, no miss.
//  3. rpad_y=0, same serve.
//     -> 8th step: miss_right for 1 cycle, no pos_valid.
//     -> pos=0x77, running=0; next serve moves +x.
//  4. Paddle edge: rpad_y=14 with ball arriving at y=14 -> hit.
//     Same with ball at y=1 -> miss (no wrap).
//  5. rst asserted asynchronously between steps 3 and 4.
//     -> pos=0x77, pulses=0, running=0 before the next clk edge.
//  6. start held high through RUN -> no counter restart; steps stay every 4 clocks.

Source files
------------

// File: rtl/pong_pkg.sv
// Constants and types shared by the pong datapath.
// The field geometry lives here so ball_motion and the plate finder agree on walls and centre.
package pong_pkg;

  localparam int WIDTH        = 16;
  localparam int BIT_OF_WIDTH = 4;

  // Ball rows/cols run MIN_POS..MAX_POS; row/col 0 and WIDTH-1 are walls/paddle columns.
  localparam int MIN_POS = 1;
  localparam int MAX_POS = WIDTH - 2;
  localparam int CENTRE  = WIDTH / 2 - 1;

  typedef logic [BIT_OF_WIDTH-1:0] coord_t;
  typedef logic [BIT_OF_WIDTH:0]   coord_ext_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MISS = 2'd2
  } state_e;

  // One extra bit keeps a paddle near the bottom wall from wrapping onto the top rows.
  function automatic logic paddle_covers(input coord_t pad_y, input coord_t y,
                                         input int unsigned len);
    coord_ext_t top_row;
    coord_ext_t bot_row;
    coord_ext_t row;
    top_row = {1'b0, pad_y};
    bot_row = top_row + coord_ext_t'(len - 1);
    row     = {1'b0, y};
    return (row >= top_row) && (row <= bot_row);
  endfunction

endpackage

// File: rtl/step_timer.sv
// Divides the clock down to one ball-step strobe every STEP_DIV clocks while enabled.
// clear holds the count at zero so a serve always starts a fresh step period.
module step_timer #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic step
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball position generator: steps diagonally, reflects off walls and paddles, flags misses.
// Feeds the plate finder/renderer with {x,y} and a one-cycle pos_valid per move.
module ball_motion
  import pong_pkg::*;
#(
  parameter int          STEP_DIV   = 4,
  parameter int unsigned PADDLE_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIT_OF_WIDTH-1:0]   lpad_y,
  input  logic [BIT_OF_WIDTH-1:0]   rpad_y,
  output logic [2*BIT_OF_WIDTH-1:0] pos,
  output logic                      pos_valid,
  output logic                      miss_left,
  output logic                      miss_right,
  output logic                      running
);

  localparam coord_t MIN_C = coord_t'(MIN_POS);
  localparam coord_t MAX_C = coord_t'(MAX_POS);
  localparam coord_t CEN_C = coord_t'(CENTRE);

  state_e state_q, state_d;
  pos_t   pos_q, pos_d;
  logic   dx_q, dx_d;
  logic   dy_q, dy_d;
  logic   pos_valid_q, pos_valid_d;
  logic   miss_left_q, miss_left_d;
  logic   miss_right_q, miss_right_d;
  logic   running_q, running_d;

  logic   in_run;
  logic   step;

  assign in_run = (state_q == ST_RUN);

  step_timer #(
    .STEP_DIV(STEP_DIV)
  ) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(!in_run),
    .en   (in_run),
    .step (step)
  );

  // Vertical motion: bounce off the top/bottom walls.
  coord_t y_nxt;
  logic   dy_nxt;

  always_comb begin
    y_nxt  = pos_q.y;
    dy_nxt = dy_q;
    if (!dy_q && pos_q.y == MIN_C) begin
      y_nxt  = MIN_C + 1'b1;
      dy_nxt = 1'b1;
    end else if (dy_q && pos_q.y == MAX_C) begin
      y_nxt  = MAX_C - 1'b1;
      dy_nxt = 1'b0;
    end else if (dy_q) begin
      y_nxt = pos_q.y + 1'b1;
    end else begin
      y_nxt = pos_q.y - 1'b1;
    end
  end

  // Horizontal motion: paddle hit tests use the row the ball occupies now.
  logic   lhit, rhit;
  logic   miss_l, miss_r;
  coord_t x_nxt;
  logic   dx_nxt;

  assign lhit = paddle_covers(lpad_y, pos_q.y, PADDLE_LEN);
  assign rhit = paddle_covers(rpad_y, pos_q.y, PADDLE_LEN);

  always_comb begin
    x_nxt  = pos_q.x;
    dx_nxt = dx_q;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (!dx_q && pos_q.x == MIN_C) begin
      if (lhit) begin
        x_nxt  = MIN_C + 1'b1;
        dx_nxt = 1'b1;
      end else begin
        miss_l = 1'b1;
      end
    end else if (dx_q && pos_q.x == MAX_C) begin
      if (rhit) begin
        x_nxt  = MAX_C - 1'b1;
        dx_nxt = 1'b0;
      end else begin
        miss_r = 1'b1;
      end
    end else if (dx_q) begin
      x_nxt = pos_q.x + 1'b1;
    end else begin
      x_nxt = pos_q.x - 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    pos_valid_d  = 1'b0;
    miss_left_d  = 1'b0;
    miss_right_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (step) begin
          if (miss_l || miss_r) begin
            // Re-serve from centre toward the side that just missed; vertical heading is kept.
            state_d      = ST_MISS;
            pos_d.x      = CEN_C;
            pos_d.y      = CEN_C;
            dx_d         = miss_r;
            miss_left_d  = miss_l;
            miss_right_d = miss_r;
          end else begin
            pos_d.x     = x_nxt;
            pos_d.y     = y_nxt;
            dx_d        = dx_nxt;
            dy_d        = dy_nxt;
            pos_valid_d = 1'b1;
          end
        end
      end
      ST_MISS: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pos_q.x      <= CEN_C;
      pos_q.y      <= CEN_C;
      dx_q         <= 1'b1;
      dy_q         <= 1'b1;
      pos_valid_q  <= 1'b0;
      miss_left_q  <= 1'b0;
      miss_right_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      pos_valid_q  <= pos_valid_d;
      miss_left_q  <= miss_left_d;
      miss_right_q <= miss_right_d;
      running_q    <= running_d;
    end
  end

  assign pos        = pos_q;
  assign pos_valid  = pos_valid_q;
  assign miss_left  = miss_left_q;
  assign miss_right = miss_right_q;
  assign running    = running_q;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: the driver queues expected step/miss events,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_ball_motion;

  localparam int STEP_DIV = 4;

  localparam logic [2:0] K_STEP = 3'b100;
  localparam logic [2:0] K_ML   = 3'b010;
  localparam logic [2:0] K_MR   = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] lpad_y;
  logic [3:0] rpad_y;
  logic [7:0] pos;
  logic       pos_valid;
  logic       miss_left;
  logic       miss_right;
  logic       running;

  always #5 clk = ~clk;

  ball_motion #(
    .STEP_DIV  (STEP_DIV),
    .PADDLE_LEN(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lpad_y    (lpad_y),
    .rpad_y    (rpad_y),
    .pos       (pos),
    .pos_valid (pos_valid),
    .miss_left (miss_left),
    .miss_right(miss_right),
    .running   (running)
  );

  typedef struct {
    logic [2:0] kind;
    logic [7:0] pos;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         serve_cyc = 0;
  logic [7:0] path [21];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse on pos_valid/miss_* must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (pos_valid || miss_left || miss_right) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got kind=%b pos=%0h at cycle %0d, required no event",
                 {pos_valid, miss_left, miss_right}, pos, cyc);
      end else begin
        e = sb.pop_front();
        check("event_kind", {29'd0, pos_valid, miss_left, miss_right}, {29'd0, e.kind});
        check("event_pos", {24'd0, pos}, {24'd0, e.pos});
        check("event_cycle", cyc, e.cyc);
        check("event_running", {31'd0, running}, {31'd0, (e.kind == K_STEP)});
      end
    end
  end

  task automatic expect_evt(input logic [2:0] kind, input logic [7:0] p, input int k);
    exp_t e;
    e.kind = kind;
    e.pos  = p;
    e.cyc  = serve_cyc + 1 + STEP_DIV * k;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic serve(input bit hold);
    @(negedge clk);
    start     = 1'b1;
    serve_cyc = cyc;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check("pos_before_first_step", {24'd0, pos}, 32'h77);
    check("running_after_start", {31'd0, running}, 32'd1);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    path = '{8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
             8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h22};
    rst    = 1'b1;
    start  = 1'b0;
    lpad_y = 4'd0;
    rpad_y = 4'd12;
    #12;
    check("reset_pos", {24'd0, pos}, 32'h77);
    check("reset_pos_valid", {31'd0, pos_valid}, 32'd0);
    check("reset_miss_left", {31'd0, miss_left}, 32'd0);
    check("reset_miss_right", {31'd0, miss_right}, 32'd0);
    check("reset_running", {31'd0, running}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Serve, right-corner hit at (14,14), back across to a left-corner hit at (1,1).
    lpad_y = 4'd0;
    rpad_y = 4'd12;
    serve(1'b0);
    for (int k = 1; k <= 21; k++) expect_evt(K_STEP, path[k-1], k);
    drain(200);
    check("running_mid_rally", {31'd0, running}, 32'd1);

    // Right paddle at row 14 catches y=14; left paddle at row 14 must not wrap onto y=1.
    do_reset();
    lpad_y = 4'd14;
    rpad_y = 4'd14;
    serve(1'b0);
    for (int k = 1; k <= 20; k++) expect_evt(K_STEP, path[k-1], k);
    expect_evt(K_ML, 8'h77, 21);
    drain(200);
    @(negedge clk);
    check("after_miss_left_running", {31'd0, running}, 32'd0);
    check("after_miss_left_pos", {24'd0, pos}, 32'h77);
    serve(1'b0);
    expect_evt(K_STEP, 8'h66, 1);
    drain(20);

    // Right miss: re-serve heads +x with dy unchanged.
    do_reset();
    lpad_y = 4'd0;
    rpad_y = 4'd0;
    serve(1'b0);
    for (int k = 1; k <= 7; k++) expect_evt(K_STEP, path[k-1], k);
    expect_evt(K_MR, 8'h77, 8);
    drain(60);
    @(negedge clk);
    check("after_miss_right_running", {31'd0, running}, 32'd0);
    check("after_miss_right_pos", {24'd0, pos}, 32'h77);
    serve(1'b0);
    expect_evt(K_STEP, 8'h88, 1);
    expect_evt(K_STEP, 8'h99, 2);
    drain(20);

    // start held high through RUN must not restart the step counter.
    do_reset();
    lpad_y = 4'd0;
    rpad_y = 4'd12;
    serve(1'b1);
    for (int k = 1; k <= 3; k++) expect_evt(K_STEP, path[k-1], k);
    drain(30);
    start = 1'b0;

    // Asynchronous reset between step 3 and step 4, while pos_valid is still high.
    do_reset();
    serve(1'b0);
    for (int k = 1; k <= 3; k++) expect_evt(K_STEP, path[k-1], k);
    for (int n = 0; n < 40 && cyc < serve_cyc + 1 + 3 * STEP_DIV; n++) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pos", {24'd0, pos}, 32'h77);
    check("async_rst_pos_valid", {31'd0, pos_valid}, 32'd0);
    check("async_rst_miss_left", {31'd0, miss_left}, 32'd0);
    check("async_rst_miss_right", {31'd0, miss_right}, 32'd0);
    check("async_rst_running", {31'd0, running}, 32'd0);
    check("steps_before_rst", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_after_rst_running", {31'd0, running}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
